apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 139 +++++++++++++
 tb/tb_apb_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester bridging a valid/ready request
// port onto a two-slave APB bus (IDLE -> SETUP -> ACCESS state machine).
//
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase that
// waits TIMEOUT cycles without PREADY (response flagged with rsp_err).
// Without the macro ACCESS waits indefinitely and rsp_err stays 0.
//
// Ports
//   PCLK, PRESETn         clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_write/addr/wdata  request direction, address, write data
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata, rsp_err    read data / abort flag, qualified by rsp_valid
//   PSEL1, PSEL2          slave selects (address MSB decode)
//   PENABLE, PWRITE       APB enable and direction
//   PADDR, PWDATA         APB address and write data
//   PREADY, PRDATA        APB ready and muxed read data
module apb_master #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [DATAWIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 PSEL1,
  output logic                 PSEL2,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0] PWDATA,
  input  logic                 PREADY,
  input  logic [DATAWIDTH-1:0] PRDATA
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT must be at least 1");
  end

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
`ifdef APB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      // Response flags are single-cycle pulses; rsp_rdata holds.
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state     <= SETUP;
            req_ready <= 1'b0;
            PADDR     <= req_addr;
            PWDATA    <= req_wdata;
            PWRITE    <= req_write;
            PSEL1     <= ~req_addr[ADDRWIDTH-1];
            PSEL2     <= req_addr[ADDRWIDTH-1];
          end else begin
            // Covers the first edge after reset release.
            req_ready <= 1'b1;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
          end
`ifdef APB_TIMEOUT_EN
          // The edge that would bring the count to TIMEOUT aborts instead.
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          PSEL1     <= 1'b0;
          PSEL2     <= 1'b0;
          PENABLE   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

  logic        PCLK;
  logic        PRESETn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL1;
  logic        PSEL2;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;

  int pass;
  int total;

  apb_master #(
    .DATAWIDTH(32),
    .ADDRWIDTH(32),
    .TIMEOUT  (4)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL1    (PSEL1),
    .PSEL2    (PSEL2),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PREADY   (PREADY),
    .PRDATA   (PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    PREADY = 1'b0; PRDATA = '0;
    #3;
    total++;
    if ({req_ready, rsp_valid, rsp_err, PSEL1, PSEL2, PENABLE, PWRITE} !== 7'b0 ||
        PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0)
      $display("FAIL reset_outputs got ctl=%b paddr=%h pwdata=%h rdata=%h exp all 0",
               {req_ready, rsp_valid, rsp_err, PSEL1, PSEL2, PENABLE, PWRITE}, PADDR, PWDATA, rsp_rdata);
    else pass++;
    tick(); tick();
    PRESETn = 1'b1;
    total++;
    if (req_ready !== 1'b0) $display("FAIL reset_ready_before_edge got=%b exp=0", req_ready);
    else pass++;
    tick();
    total++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready_after_edge got=%b exp=1", req_ready);
    else pass++;
  endtask

  task automatic test_read();
    int psel_cnt;
    int pen_cnt;
    psel_cnt = 0; pen_cnt = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0010; req_wdata = 32'hFFFF_FFFF;
    PREADY = 1'b1; PRDATA = 32'h0BAD_0BAD;  // ignored in SETUP
    tick();  // accept edge T
    req_valid = 1'b0;
    total++;
    if (PSEL1 !== 1'b1 || PSEL2 !== 1'b0 || PENABLE !== 1'b0 || req_ready !== 1'b0 ||
        PADDR !== 32'h0000_0010 || PWRITE !== 1'b0)
      $display("FAIL rd_setup got psel=%b%b pen=%b rdy=%b paddr=%h pwrite=%b exp 10/0/0/00000010/0",
               PSEL1, PSEL2, PENABLE, req_ready, PADDR, PWRITE);
    else pass++;
    psel_cnt += int'(PSEL1); pen_cnt += int'(PENABLE);
    PRDATA = 32'hDEAD_BEEF;
    tick();  // T+1 -> ACCESS
    total++;
    if (PENABLE !== 1'b1 || PSEL1 !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL rd_access got pen=%b psel1=%b rsp_valid=%b exp 1/1/0", PENABLE, PSEL1, rsp_valid);
    else pass++;
    psel_cnt += int'(PSEL1); pen_cnt += int'(PENABLE);
    tick();  // T+2 completes
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0)
      $display("FAIL rd_complete got valid=%b rdata=%h err=%b exp 1/deadbeef/0", rsp_valid, rsp_rdata, rsp_err);
    else pass++;
    total++;
    if (PSEL1 !== 1'b0 || PENABLE !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL rd_idle got psel1=%b pen=%b rdy=%b exp 0/0/1", PSEL1, PENABLE, req_ready);
    else pass++;
    psel_cnt += int'(PSEL1); pen_cnt += int'(PENABLE);
    PRDATA = 32'h5555_AAAA;
    tick();
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF)
      $display("FAIL rd_hold got valid=%b rdata=%h exp 0/deadbeef", rsp_valid, rsp_rdata);
    else pass++;
    total++;
    if (psel_cnt != 2 || pen_cnt != 1)
      $display("FAIL rd_pulse_widths got psel=%0d pen=%0d exp psel=2 pen=1", psel_cnt, pen_cnt);
    else pass++;
  endtask

  task automatic test_write_wait();
    int vcnt;
    vcnt = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8000_0004; req_wdata = 32'h1234_5678;
    PREADY = 1'b0; PRDATA = 32'hFACE_FACE;
    tick();  // accept edge T
    req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (PSEL2 !== 1'b1 || PSEL1 !== 1'b0 || PADDR !== 32'h8000_0004 ||
          PWDATA !== 32'h1234_5678 || PWRITE !== 1'b1 || PENABLE !== (i > 0) || rsp_valid !== 1'b0)
        $display("FAIL wr_hold[%0d] got psel=%b%b paddr=%h pwdata=%h pwrite=%b pen=%b valid=%b exp 01/80000004/12345678/1/%b/0",
                 i, PSEL1, PSEL2, PADDR, PWDATA, PWRITE, PENABLE, rsp_valid, (i > 0));
      else pass++;
      PREADY = (i == 4);
      tick();
    end
    PREADY = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || PSEL2 !== 1'b0)
      $display("FAIL wr_complete got valid=%b rdata=%h err=%b psel2=%b exp 1/0/0/0", rsp_valid, rsp_rdata, rsp_err, PSEL2);
    else pass++;
    for (int i = 0; i < 4; i++) begin
      vcnt += int'(rsp_valid);
      tick();
    end
    total++;
    if (vcnt != 1) $display("FAIL wr_single_rsp got=%0d exp=1", vcnt);
    else pass++;
  endtask

  task automatic test_back_to_back();
    int done;
    int bad_ready;
    done = 0; bad_ready = 0;
    PREADY = 1'b1; PRDATA = 32'h0000_0011;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0020; req_wdata = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      done += int'(rsp_valid);
      if (req_ready === (PSEL1 | PSEL2)) bad_ready++;
    end
    req_valid = 1'b0;
    total++;
    if (done != 3) $display("FAIL b2b_completions got=%0d exp=3", done);
    else pass++;
    total++;
    if (bad_ready != 0) $display("FAIL b2b_ready_busy got=%0d cycles exp=0", bad_ready);
    else pass++;
    tick(); tick(); tick();
    total++;
    if (req_ready !== 1'b1 || PSEL1 !== 1'b0) $display("FAIL b2b_drain got rdy=%b psel1=%b exp 1/0", req_ready, PSEL1);
    else pass++;
  endtask

  task automatic test_reset_mid_access();
    int vcnt;
    vcnt = 0;
    PREADY = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8000_0100; req_wdata = 32'hA5A5_A5A5;
    tick();
    req_valid = 1'b0;
    tick();  // now in ACCESS
    total++;
    if (PENABLE !== 1'b1 || PSEL2 !== 1'b1) $display("FAIL rst_pre got pen=%b psel2=%b exp 1/1", PENABLE, PSEL2);
    else pass++;
    #2 PRESETn = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_err, PSEL1, PSEL2, PENABLE, PWRITE} !== 7'b0 ||
        PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0)
      $display("FAIL rst_async got ctl=%b paddr=%h pwdata=%h rdata=%h exp all 0",
               {req_ready, rsp_valid, rsp_err, PSEL1, PSEL2, PENABLE, PWRITE}, PADDR, PWDATA, rsp_rdata);
    else pass++;
    PREADY = 1'b1;
    tick();
    PRESETn = 1'b1;
    total++;
    if (req_ready !== 1'b0) $display("FAIL rst_mid_ready_early got=%b exp=0", req_ready);
    else pass++;
    tick();
    total++;
    if (req_ready !== 1'b1) $display("FAIL rst_mid_ready_release got=%b exp=1", req_ready);
    else pass++;
    for (int i = 0; i < 3; i++) begin
      vcnt += int'(rsp_valid);
      tick();
    end
    total++;
    if (vcnt != 0 || PSEL2 !== 1'b0) $display("FAIL rst_no_rsp got valid_cnt=%0d psel2=%b exp 0/0", vcnt, PSEL2);
    else pass++;
    PREADY = 1'b0;
  endtask

  task automatic test_stall();
    int low;
    low = 0;
    PREADY = 1'b0; PRDATA = 32'hCAFE_F00D;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040; req_wdata = '0;
    tick();  // accept edge T
    req_valid = 1'b0;
`ifdef APB_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (PSEL1 !== 1'b1 || rsp_valid !== 1'b0) low++;
    end
    total++;
    if (low != 0) $display("FAIL to_wait got early_end=%0d exp=0", low);
    else pass++;
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || PSEL1 !== 1'b0 || PENABLE !== 1'b0)
      $display("FAIL to_abort got valid=%b err=%b rdata=%h psel1=%b pen=%b exp 1/1/0/0/0",
               rsp_valid, rsp_err, rsp_rdata, PSEL1, PENABLE);
    else pass++;
    tick();
`else
    for (int k = 0; k < 60; k++) begin
      tick();
      if (PSEL1 !== 1'b1 || PENABLE !== 1'b1 || rsp_valid !== 1'b0) low++;
    end
    total++;
    if (low != 0) $display("FAIL stall_hold got bad_cycles=%0d exp=0", low);
    else pass++;
    PREADY = 1'b1;
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFE_F00D)
      $display("FAIL stall_release got valid=%b err=%b rdata=%h exp 1/0/cafef00d", rsp_valid, rsp_err, rsp_rdata);
    else pass++;
    PREADY = 1'b0;
    tick();
`endif
    total++;
    if (req_ready !== 1'b1) $display("FAIL stall_idle got rdy=%b exp=1", req_ready);
    else pass++;
  endtask

  initial begin
    pass = 0;
    total = 0;
    test_reset();
    test_read();
    test_write_wait();
    test_back_to_back();
    test_reset_mid_access();
    test_stall();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
